// File: rtl/toeplitz_ctrl.sv
// toeplitz_ctrl
//   Sequencer for the Toeplitz column generator (gencol). It loads the
//   matrix seed (first row of N bits, then first column of L bits) from a
//   BS-bit word stream, primes gencol with a one-cycle engine reset, and
//   then runs one pass of N/STRIDE columns per start request. Each valid
//   column is tagged with its index.
//
// Ports
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   seed_data   in   BS-bit seed word
//   seed_valid  in   seed word valid
//   seed_ready  out  controller accepts a seed word (LOAD_ROW / LOAD_COL)
//   reseed      in   pulse: discard the seed and reload from row word 0
//   start       in   request one pass (honoured in READY only)
//   row0        out  first row to gencol (N bits)
//   rrow0       out  bit-reversed row0, rrow0[i] = row0[N-1-i]
//   col0        out  first column to gencol (L bits)
//   eng_reset   out  gencol reset: reset OR state PRIME
//   busy        out  PRIME or RUN
//   col_valid   out  gencol column is valid this cycle
//   col_idx     out  index of the current column
//   block_done  out  one-cycle pulse on the last column of a pass
//   pass_cnt    out  completed passes, wraps at 2^PCW
//
// Configuration macro
//   TOEPLITZ_CONT_EN : when defined, start held high in the last RUN cycle
//                      keeps the controller in RUN with no PRIME cycle.

module toeplitz_ctrl #(
   parameter int BS     = 64,
   parameter int N      = 256,
   parameter int L      = 128,
   parameter int STRIDE = 1,
   parameter int PCW    = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [BS-1:0]                 seed_data,
   input  logic                          seed_valid,
   output logic                          seed_ready,
   input  logic                          reseed,
   input  logic                          start,
   output logic [N-1:0]                  row0,
   output logic [N-1:0]                  rrow0,
   output logic [L-1:0]                  col0,
   output logic                          eng_reset,
   output logic                          busy,
   output logic                          col_valid,
   output logic [$clog2(N/STRIDE)-1:0]   col_idx,
   output logic                          block_done,
   output logic [PCW-1:0]                pass_cnt
);

   localparam int NW   = N / BS;
   localparam int LW   = L / BS;
   localparam int MAXW = (NW > LW) ? NW : LW;
   localparam int WCW  = (MAXW > 1) ? $clog2(MAXW) : 1;
   localparam int CIW  = $clog2(N / STRIDE);
   localparam logic [CIW-1:0] LAST_IDX = CIW'(N / STRIDE - 1);

   typedef enum logic [2:0] {
      S_LOAD_ROW,
      S_LOAD_COL,
      S_READY,
      S_PRIME,
      S_RUN
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [WCW-1:0]   r_wordCnt;
   logic [N-1:0]     r_row0;
   logic [L-1:0]     r_col0;
   logic [CIW-1:0]   r_colIdx;
   logic [PCW-1:0]   r_passCnt;
   logic             w_xfer;
   logic             w_lastRowWord;
   logic             w_lastColWord;
   logic             w_lastCol;

   assign w_xfer        = seed_valid & seed_ready;
   assign w_lastRowWord = (r_wordCnt == WCW'(NW - 1));
   assign w_lastColWord = (r_wordCnt == WCW'(LW - 1));
   assign w_lastCol     = (r_colIdx == LAST_IDX);

   // Next-state decode plus the state-derived outputs. reseed has priority
   // over both seed transfers and start; it is ignored while busy.
   always_comb begin
      w_nextState = r_state;
      seed_ready  = 1'b0;
      busy        = 1'b0;
      col_valid   = 1'b0;
      block_done  = 1'b0;
      case (r_state)
         S_LOAD_ROW: begin
            seed_ready = 1'b1;
            if (reseed)
               w_nextState = S_LOAD_ROW;
            else if (w_xfer && w_lastRowWord)
               w_nextState = S_LOAD_COL;
         end
         S_LOAD_COL: begin
            seed_ready = 1'b1;
            if (reseed)
               w_nextState = S_LOAD_ROW;
            else if (w_xfer && w_lastColWord)
               w_nextState = S_READY;
         end
         S_READY: begin
            if (reseed)
               w_nextState = S_LOAD_ROW;
            else if (start)
               w_nextState = S_PRIME;
         end
         S_PRIME: begin
            busy        = 1'b1;
            w_nextState = S_RUN;
         end
         S_RUN: begin
            busy      = 1'b1;
            col_valid = 1'b1;
            if (w_lastCol) begin
               block_done = 1'b1;
`ifdef TOEPLITZ_CONT_EN
               w_nextState = start ? S_RUN : S_READY;
`else
               w_nextState = S_READY;
`endif
            end
         end
         default: w_nextState = S_LOAD_ROW;
      endcase
   end

   // State register, seed word counter and seed storage, column index and
   // pass counter. A word arriving in the same cycle as reseed is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_LOAD_ROW;
         r_wordCnt <= '0;
         r_row0    <= '0;
         r_col0    <= '0;
         r_colIdx  <= '0;
         r_passCnt <= '0;
      end else begin
         r_state <= w_nextState;
         if (reseed && (r_state == S_LOAD_ROW || r_state == S_LOAD_COL ||
                        r_state == S_READY)) begin
            r_wordCnt <= '0;
         end else if (w_xfer) begin
            if ((r_state == S_LOAD_ROW && w_lastRowWord) ||
                (r_state == S_LOAD_COL && w_lastColWord))
               r_wordCnt <= '0;
            else
               r_wordCnt <= r_wordCnt + 1'b1;
            for (int k = 0; k < NW; k++) begin
               if (r_state == S_LOAD_ROW && r_wordCnt == WCW'(k))
                  r_row0[k*BS +: BS] <= seed_data;
            end
            for (int k = 0; k < LW; k++) begin
               if (r_state == S_LOAD_COL && r_wordCnt == WCW'(k))
                  r_col0[k*BS +: BS] <= seed_data;
            end
         end
         if (r_state == S_PRIME) begin
            r_colIdx <= '0;
         end else if (r_state == S_RUN) begin
            r_colIdx <= w_lastCol ? '0 : r_colIdx + 1'b1;
            if (w_lastCol)
               r_passCnt <= r_passCnt + 1'b1;
         end
      end
   end

   // The reversed row is pure wiring, so it tracks row0 with no extra delay.
   always_comb begin
      rrow0 = '0;
      for (int i = 0; i < N; i++)
         rrow0[i] = r_row0[N-1-i];
   end

   assign row0      = r_row0;
   assign col0      = r_col0;
   assign col_idx   = r_colIdx;
   assign pass_cnt  = r_passCnt;
   assign eng_reset = reset | (r_state == S_PRIME);

endmodule

// File: tb/tb_toeplitz_ctrl.sv
// Self-checking bench for toeplitz_ctrl (N=256, L=128, BS=64). A second
// instance with STRIDE=4 shares all inputs so the shorter pass can be checked.
// Define TOEPLITZ_CONT_EN for both bench and RTL to check continuous mode.

module tb_toeplitz_ctrl;

   localparam int BS  = 64;
   localparam int N   = 256;
   localparam int L   = 128;
   localparam int PCW = 16;
   localparam int NW  = N / BS;
   localparam int LW  = L / BS;

   logic           clk = 1'b0;
   logic           reset;
   logic [BS-1:0]  seedData;
   logic           seedValid;
   logic           reseed;
   logic           start;

   logic           seedReady, engReset, busy, colValid, blockDone;
   logic [N-1:0]   row0, rrow0;
   logic [L-1:0]   col0;
   logic [7:0]     colIdx;
   logic [PCW-1:0] passCnt;

   logic           seedReady4, engReset4, busy4, colValid4, blockDone4;
   logic [N-1:0]   row04, rrow04;
   logic [L-1:0]   col04;
   logic [5:0]     colIdx4;
   logic [PCW-1:0] passCnt4;

   int vecCnt = 0;
   int errCnt = 0;

   logic [N-1:0] mRow;
   logic [L-1:0] mCol;

   bit mon4 = 0;
   int cnt4 = 0;
   int doneCnt4 = 0;
   int doneIdx4 = -1;

   typedef struct {
      logic start;
      logic reseed;
      logic seedValid;
      logic expReady;
      logic expBusy;
      logic expEng;
      logic expValid;
      int   expIdx;
   } vec_t;

   vec_t tbl[7];

   always #5 clk = ~clk;

   toeplitz_ctrl #(.BS(BS), .N(N), .L(L), .STRIDE(1), .PCW(PCW)) u_dut (
      .clk(clk), .reset(reset), .seed_data(seedData), .seed_valid(seedValid),
      .seed_ready(seedReady), .reseed(reseed), .start(start), .row0(row0),
      .rrow0(rrow0), .col0(col0), .eng_reset(engReset), .busy(busy),
      .col_valid(colValid), .col_idx(colIdx), .block_done(blockDone),
      .pass_cnt(passCnt)
   );

   toeplitz_ctrl #(.BS(BS), .N(N), .L(L), .STRIDE(4), .PCW(PCW)) u_dut4 (
      .clk(clk), .reset(reset), .seed_data(seedData), .seed_valid(seedValid),
      .seed_ready(seedReady4), .reseed(reseed), .start(start), .row0(row04),
      .rrow0(rrow04), .col0(col04), .eng_reset(engReset4), .busy(busy4),
      .col_valid(colValid4), .col_idx(colIdx4), .block_done(blockDone4),
      .pass_cnt(passCnt4)
   );

   // Observe the STRIDE=4 instance mid-cycle while its pass is being watched.
   always @(negedge clk) begin
      if (mon4) begin
         if (colValid4) cnt4++;
         if (blockDone4) begin
            doneCnt4++;
            doneIdx4 = int'(colIdx4);
         end
      end
   end

   function automatic logic [N-1:0] revBits(input logic [N-1:0] v);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = v[N-1-i];
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [N-1:0] act,
                              input logic [N-1:0] exp);
      vecCnt++;
      if (act !== exp) begin
         errCnt++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      vecCnt++;
      errCnt++;
      $display("[TB] FAIL %s: wait budget expired", name);
   endtask

   // Feeds nWords seed words with random stalls; start is toggled randomly
   // and must have no effect while loading.
   task automatic applyStimulus(input int nWords, input bit det);
      int cnt = 0;
      int guard = 0;
      while (cnt < nWords && guard < 400) begin
         guard++;
         seedValid = ($urandom_range(0, 3) != 0);
         seedData  = det ? BS'(cnt + 1) : {$urandom, $urandom};
         start     = 1'($urandom_range(0, 1));
         step();
         if (seedValid) begin
            if (cnt < NW) mRow[cnt*BS +: BS] = seedData;
            else          mCol[(cnt-NW)*BS +: BS] = seedData;
            cnt++;
         end
         checkOutput("seed_ready", N'(seedReady), N'(cnt < NW + LW));
         checkOutput("busy_load", N'(busy), '0);
      end
      if (cnt < nWords) timeoutFail("seed_load");
      seedValid = 1'b0;
      start     = 1'b0;
   endtask

   task automatic checkSeed();
      checkOutput("row0", row0, mRow);
      checkOutput("col0", N'(col0), N'(mCol));
      checkOutput("rrow0", rrow0, revBits(mRow));
   endtask

   // Runs the rest of a pass after the given index, checking each column.
   task automatic finishPass(input int fromIdx, input int expPass);
      int idx = fromIdx;
      bit ended = 0;
      for (int c = 0; c < 400 && !ended; c++) begin
         step();
         idx++;
         checkOutput("col_valid", N'(colValid), N'(1));
         checkOutput("col_idx", N'(colIdx), N'(idx));
         checkOutput("block_done", N'(blockDone), N'(idx == N - 1));
         if (idx >= N - 1) ended = 1;
      end
      if (!ended) timeoutFail("pass_end");
      step();
      checkOutput("pass_cnt", N'(passCnt), N'(expPass));
      checkOutput("busy_after", N'(busy), '0);
      checkOutput("valid_after", N'(colValid), '0);
   endtask

   initial begin
      int validCnt, engCnt, doneCnt, firstCyc, lastCyc, cyc, expEng, expSpan;
      bit ended;
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3};

      reset = 1'b1; seedData = '0; seedValid = 1'b0; reseed = 1'b0; start = 1'b0;
      mRow = '0; mCol = '0;
      step(); step();
      checkOutput("eng_reset_in_reset", N'(engReset), N'(1));
      checkOutput("reset_seed_ready", N'(seedReady), N'(1));
      checkOutput("reset_busy", N'(busy), '0);
      checkOutput("reset_valid", N'(colValid), '0);
      checkOutput("reset_done", N'(blockDone), '0);
      checkOutput("reset_idx", N'(colIdx), '0);
      checkOutput("reset_pass", N'(passCnt), '0);
      checkSeed();
      reset = 1'b0;
      #1;
      checkOutput("eng_reset_released", N'(engReset), '0);

      $display("[TB] deterministic seed load");
      applyStimulus(NW + LW, 1'b1);
      checkSeed();
      checkOutput("row0_word0", N'(row0[63:0]), N'(1));
      checkOutput("rrow0_msb", N'(rrow0[255]), N'(1));

      $display("[TB] first pass, table vectors");
      mon4 = 1;
      for (int v = 0; v < 7; v++) begin
         start = tbl[v].start; reseed = tbl[v].reseed; seedValid = tbl[v].seedValid;
         seedData = {$urandom, $urandom};
         step();
         checkOutput($sformatf("tbl%0d_ready", v), N'(seedReady), N'(tbl[v].expReady));
         checkOutput($sformatf("tbl%0d_busy", v), N'(busy), N'(tbl[v].expBusy));
         checkOutput($sformatf("tbl%0d_eng", v), N'(engReset), N'(tbl[v].expEng));
         checkOutput($sformatf("tbl%0d_valid", v), N'(colValid), N'(tbl[v].expValid));
         checkOutput($sformatf("tbl%0d_idx", v), N'(colIdx), N'(tbl[v].expIdx));
      end
      start = 1'b0; reseed = 1'b0; seedValid = 1'b0;
      finishPass(3, 1);
      checkSeed();
      mon4 = 0;
      checkOutput("s4_columns", N'(cnt4), N'(N / 4));
      checkOutput("s4_done_count", N'(doneCnt4), N'(1));
      checkOutput("s4_done_idx", N'(doneIdx4), N'(N / 4 - 1));
      checkOutput("s4_pass", N'(passCnt4), N'(1));

      $display("[TB] start and reseed together in READY");
      start = 1'b1; reseed = 1'b1;
      step();
      start = 1'b0; reseed = 1'b0;
      checkOutput("sr_ready", N'(seedReady), N'(1));
      checkOutput("sr_eng", N'(engReset), '0);
      checkOutput("sr_busy", N'(busy), '0);
      step();
      checkOutput("sr_no_prime", N'(busy), '0);
      checkSeed();

      $display("[TB] reseed mid-load, then random reload");
      applyStimulus(2, 1'b0);
      reseed = 1'b1;
      step();
      reseed = 1'b0;
      checkOutput("reseed_ready", N'(seedReady), N'(1));
      applyStimulus(NW + LW, 1'b0);
      checkSeed();

      $display("[TB] second pass then reset at column 100");
      start = 1'b1;
      step();
      start = 1'b0;
      ended = 0;
      for (int c = 0; c < 400 && !ended; c++) begin
         step();
         if (colValid && colIdx == 8'd100) ended = 1;
      end
      if (!ended) timeoutFail("reach_idx100");
      reset = 1'b1;
      #1;
      checkOutput("mid_eng_reset", N'(engReset), N'(1));
      step();
      checkOutput("mid_valid", N'(colValid), '0);
      checkOutput("mid_done", N'(blockDone), '0);
      checkOutput("mid_pass", N'(passCnt), '0);
      checkOutput("mid_ready", N'(seedReady), N'(1));
      checkOutput("mid_idx", N'(colIdx), '0);
      reset = 1'b0;
      mRow = '0; mCol = '0;
      checkSeed();

      $display("[TB] start held across three passes");
      applyStimulus(NW + LW, 1'b0);
      start = 1'b1;
      validCnt = 0; engCnt = 0; doneCnt = 0; firstCyc = -1; lastCyc = -1; cyc = 0;
      ended = 0;
      while (!ended && cyc < 2000) begin
         step();
         cyc++;
         if (colValid) begin
            validCnt++;
            if (firstCyc < 0) firstCyc = cyc;
            lastCyc = cyc;
         end
         if (engReset) engCnt++;
         if (blockDone) doneCnt++;
         if (validCnt >= 2 * N + 10) start = 1'b0;
         if (passCnt == PCW'(3) && !busy) ended = 1;
      end
      start = 1'b0;
      if (!ended) timeoutFail("three_passes");
`ifdef TOEPLITZ_CONT_EN
      expEng  = 1;
      expSpan = 3 * N;
`else
      expEng  = 3;
      expSpan = 3 * N + 4;
`endif
      checkOutput("cont_valid_cycles", N'(validCnt), N'(3 * N));
      checkOutput("cont_eng_pulses", N'(engCnt), N'(expEng));
      checkOutput("cont_span", N'(lastCyc - firstCyc + 1), N'(expSpan));
      checkOutput("cont_done_count", N'(doneCnt), N'(3));
      checkOutput("cont_pass", N'(passCnt), N'(3));

      $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
      $finish;
   end

endmodule

// File: doc/toeplitz_ctrl.md
Name: toeplitz_ctrl

Overview:
Sequencer for the Toeplitz column generator (gencol).
- Loads the matrix seed (first row, N bits; first column, L bits) from a BS-bit word stream and derives the reversed row.
- Primes gencol, then runs one pass of N/STRIDE columns per start request, tagging each valid column with its index.
- Sits between the seed source (QRNG/host FIFO) and the gencol instances of the extractor.

Parameters:
BS, 64, seed word width; N and L are multiples of BS
N, 256, row length (input block bits); multiple of STRIDE
L, 128, column length (output bits)
STRIDE, 1, columns advanced per clock, must match gencol STRIDE
PCW, 16, pass counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
seed_data  in  BS  seed word
seed_valid  in  1  seed word valid
seed_ready  out  1  controller accepts seed word
reseed  in  1  pulse: discard seed, reload
start  in  1  request one pass
row0  out  N  first row to gencol
rrow0  out  N  bit-reversed row0: rrow0[i] = row0[N-1-i]
col0  out  L  first column to gencol
eng_reset  out  1  drives gencol reset
busy  out  1  PRIME or RUN
col_valid  out  1  gencol col is a valid column this cycle
col_idx  out  $clog2(N/STRIDE)  index of current column
block_done  out  1  one-cycle pulse on last column of a pass
pass_cnt  out  PCW  completed passes, wraps

Behaviour:
- Reset: state LOAD_ROW; row0, col0, rrow0 = 0; seed_ready=1; busy, col_valid, block_done = 0; col_idx, pass_cnt = 0; eng_reset=1. Reset mid-pass aborts immediately; no block_done.
- eng_reset = reset OR (state==PRIME), combinational.
- Transfer = seed_valid & seed_ready. seed_ready=1 only in LOAD_ROW/LOAD_COL.
- LOAD_ROW: word k (k=0..N/BS-1) written to row0[k*BS +: BS]. After word N/BS-1 -> LOAD_COL.
- LOAD_COL: word k written to col0[k*BS +: BS]. After word L/BS-1 -> READY.
- rrow0 is combinationally derived from row0; it is not a separate register.
- READY: reseed -> LOAD_ROW with word counter cleared; row0/col0 keep old value until overwritten. Otherwise start -> PRIME. reseed and start together: reseed wins.
- PRIME (1 cycle): eng_reset=1, busy=1 -> RUN.
- RUN: col_valid=1, busy=1. col_idx starts at 0 and increments each cycle up to N/STRIDE-1. On col_idx=N/STRIDE-1, block_done=1, pass_cnt+1 (wrap at 2^PCW) -> READY. gencol's internal wrap coincides with this cycle.
- Latency: start sampled at edge t; eng_reset high in cycle t+1; column 0 valid in cycle t+2.
- Inputs ignored while busy: start, reseed. In LOAD_*: start ignored. reseed in LOAD_* restarts at LOAD_ROW word 0.
- No backpressure on columns; the consumer must accept every col_valid cycle.

Optional Feature:
TOEPLITZ_CONT_EN:
- Defined: if start=1 in the last RUN cycle, the controller stays in RUN with col_idx wrapping to 0 and no PRIME cycle (gencol self-reloads). block_done and pass_cnt still update every pass. reseed still ignored until READY.
- Undefined: the controller always returns to READY after a pass; each pass costs N/STRIDE+1 cycles after start.

Test Plan:
- Reset, then 4 row words 0x...01..0x...04 and 2 col words (N=256, L=128, BS=64) -> seed_ready drops after 6th transfer; row0[63:0]=word0; rrow0[255]=row0[0].
- Start in READY -> eng_reset high exactly 1 cycle; col_valid for 256 cycles, col_idx 0..255; block_done only with col_idx=255; pass_cnt=1.
- STRIDE=4 -> 64 valid columns, block_done at col_idx=63.
- start+reseed same cycle in READY -> LOAD_ROW, no PRIME; start during RUN ignored; seed_valid stalls mid-load preserve word count.
- Reset at col_idx=100 -> next cycle col_valid=0, state LOAD_ROW, pass_cnt=0, no block_done.
- With TOEPLITZ_CONT_EN and start held -> 3 back-to-back passes, 768 contiguous col_valid cycles, one eng_reset pulse total, pass_cnt=3.
